// File: rtl/midi_voice_allocator.sv
// ---------------------------------------------------------------------------
// midi_voice_allocator
//
// Purpose:
//   Parses a raw MIDI byte stream into note-on / note-off events for one MIDI
//   channel and assigns those notes to NUM_VOICES oscillator voices. For each
//   voice it drives a note number, a gate, and a one-cycle update strobe.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   midi_data     MIDI byte, sampled on every clk edge where midi_valid is high
//   midi_valid    byte qualifier (no backpressure)
//   voice_note    packed note numbers, voice i at bits [7i+6:7i]
//   voice_gate    1 = voice i sounding
//   voice_update  one-cycle pulse when voice i is (re)triggered by a note-on
//   overflow      sticky flag, set when a note-on had to be dropped
//
// Configuration:
//   MIDI_VOICE_STEAL_EN  when defined, a note-on arriving with every voice busy
//                        steals the oldest voice instead of being dropped.
// ---------------------------------------------------------------------------
module midi_voice_allocator #(
    parameter int         NUM_VOICES   = 4,
    parameter logic [3:0] MIDI_CHANNEL = 4'd0,
    parameter int         AGE_BITS     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              midi_data,
    input  logic                    midi_valid,
    output logic [NUM_VOICES*7-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_update,
    output logic                    overflow
);

    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

    typedef enum logic [2:0] {IDLE, DATA1, DATA2, SKIP1, SKIP2} parseState_e;

    parseState_e state_q, state_d;
    logic        runValid_q, runValid_d;
    logic        runIsOn_q, runIsOn_d;
    logic [3:0]  runCh_q, runCh_d;
    logic [6:0]  note_q, note_d;
    logic        evtValid_q, evtValid_d;
    logic        evtOn_q, evtOn_d;
    logic [6:0]  evtNote_q, evtNote_d;

    logic [6:0]          noteV_q [NUM_VOICES];
    logic [6:0]          noteV_d [NUM_VOICES];
    logic [AGE_BITS-1:0] age_q   [NUM_VOICES];
    logic [AGE_BITS-1:0] age_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] update_q, update_d;
    logic                  overflow_q, overflow_d;

    logic [NUM_VOICES-1:0] matchSel, freeSel, trig;
    logic                  anyMatch, anyFree;
`ifdef MIDI_VOICE_STEAL_EN
    logic [NUM_VOICES-1:0] stealSel;
    logic [AGE_BITS-1:0]   bestAge;
`endif

    // Parser state and the one-cycle event register that separates message
    // completion from the voice update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            runValid_q <= 1'b0;
            runIsOn_q  <= 1'b0;
            runCh_q    <= 4'd0;
            note_q     <= 7'd0;
            evtValid_q <= 1'b0;
            evtOn_q    <= 1'b0;
            evtNote_q  <= 7'd0;
        end else begin
            state_q    <= state_d;
            runValid_q <= runValid_d;
            runIsOn_q  <= runIsOn_d;
            runCh_q    <= runCh_d;
            note_q     <= note_d;
            evtValid_q <= evtValid_d;
            evtOn_q    <= evtOn_d;
            evtNote_q  <= evtNote_d;
        end
    end

    // Byte classification and message assembly. Real-time bytes leave every
    // register untouched so they can sit anywhere inside a message.
    always_comb begin
        state_d    = state_q;
        runValid_d = runValid_q;
        runIsOn_d  = runIsOn_q;
        runCh_d    = runCh_q;
        note_d     = note_q;
        evtValid_d = 1'b0;
        evtOn_d    = 1'b0;
        evtNote_d  = evtNote_q;
        if (midi_valid) begin
            if (midi_data[7:3] == 5'b11111) begin
                state_d = state_q;
            end else if (midi_data[7:4] == 4'hF) begin
                runValid_d = 1'b0;
                state_d    = IDLE;
            end else if (midi_data[7]) begin
                case (midi_data[6:4])
                    3'b000, 3'b001: begin
                        runValid_d = 1'b1;
                        runIsOn_d  = midi_data[4];
                        runCh_d    = midi_data[3:0];
                        state_d    = DATA1;
                    end
                    3'b100, 3'b101: begin
                        runValid_d = 1'b0;
                        state_d    = SKIP1;
                    end
                    default: begin
                        runValid_d = 1'b0;
                        state_d    = SKIP2;
                    end
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        if (runValid_q) begin
                            note_d  = midi_data[6:0];
                            state_d = DATA2;
                        end
                    end
                    DATA1: begin
                        note_d  = midi_data[6:0];
                        state_d = DATA2;
                    end
                    DATA2: begin
                        state_d = IDLE;
                        // A note-on with velocity zero is a note-off.
                        if (runCh_q == MIDI_CHANNEL) begin
                            evtValid_d = 1'b1;
                            evtOn_d    = runIsOn_q && (midi_data[6:0] != 7'd0);
                            evtNote_d  = note_q;
                        end
                    end
                    SKIP2:   state_d = SKIP1;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Voice registers: notes, gates, ages, the update strobe and overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                noteV_q[i] <= 7'd0;
                age_q[i]   <= '0;
            end
            gate_q     <= '0;
            update_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                noteV_q[i] <= noteV_d[i];
                age_q[i]   <= age_d[i];
            end
            gate_q     <= gate_d;
            update_q   <= update_d;
            overflow_q <= overflow_d;
        end
    end

    // Allocation: retrigger a sounding voice holding the same note first,
    // then the lowest free voice, and only then fall back to stealing or
    // dropping. The trigger vector is one-hot or empty.
    always_comb begin
        noteV_d    = noteV_q;
        age_d      = age_q;
        gate_d     = gate_q;
        update_d   = '0;
        overflow_d = overflow_q;
        matchSel   = '0;
        freeSel    = '0;
        trig       = '0;
        anyMatch   = 1'b0;
        anyFree    = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!anyMatch && gate_q[i] && (noteV_q[i] == evtNote_q)) begin
                matchSel[i] = 1'b1;
                anyMatch    = 1'b1;
            end
            if (!anyFree && !gate_q[i]) begin
                freeSel[i] = 1'b1;
                anyFree    = 1'b1;
            end
        end
`ifdef MIDI_VOICE_STEAL_EN
        // Strict greater-than keeps the lowest index on equal ages.
        stealSel = '0;
        bestAge  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (i == 0 || age_q[i] > bestAge) begin
                stealSel    = '0;
                stealSel[i] = 1'b1;
                bestAge     = age_q[i];
            end
        end
`endif
        if (evtValid_q) begin
            if (evtOn_q) begin
                if (anyMatch) begin
                    trig = matchSel;
                end else if (anyFree) begin
                    trig = freeSel;
                end else begin
`ifdef MIDI_VOICE_STEAL_EN
                    trig = stealSel;
`else
                    overflow_d = 1'b1;
`endif
                end
                // A dropped note-on leaves every voice, including ages, as is.
                if (|trig) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (trig[i]) begin
                            noteV_d[i]  = evtNote_q;
                            gate_d[i]   = 1'b1;
                            age_d[i]    = '0;
                            update_d[i] = 1'b1;
                        end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
                            age_d[i] = age_q[i] + AGE_BITS'(1);
                        end
                    end
                end
            end else begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (gate_q[i] && (noteV_q[i] == evtNote_q)) begin
                        gate_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Pack per-voice note registers onto the flat output bus.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : gPack
        assign voice_note[7*g +: 7] = noteV_q[g];
    end

    assign voice_gate   = gate_q;
    assign voice_update = update_q;
    assign overflow     = overflow_q;

endmodule
